// File: rtl/minmax_frame_feeder.sv
// Feeds a buffered sample stream to the min/max filter in frames and returns the mid-range per frame.
// Samples can be popped one cycle after push; the result is valid one cycle after frame end; a full result slot stalls the frame end.

module minmax_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module minmax_frame_feeder #(
  parameter  int MSB       = 8,
  parameter  int FRAME_LEN = 16,
  parameter  int DEPTH     = 4,
  localparam int CW        = $clog2(FRAME_LEN+1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [MSB:0]  s_data,
  input  logic          s_flush,
  output logic [MSB:0]  f_in,
  output logic          f_clear,
  output logic          f_enable,
  output logic          f_reset,
  input  logic [MSB:0]  f_out,
  output logic          r_valid,
  input  logic          r_ready,
  output logic [MSB:0]  r_data,
  output logic [CW-1:0] r_count,
  output logic          busy
);
  typedef enum logic [1:0] {ST_CLR, ST_IDLE, ST_RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [MSB:0]  hold_q, hold_nxt;
  logic          flush_pend, flush_pend_nxt;
  logic          r_valid_q;
  logic [MSB:0]  r_data_q;
  logic [CW-1:0] r_count_q;

  logic          push, pop, empty, full;
  logic [MSB:0]  head;
  logic          slot_free;
  logic          capture;
  logic [CW-1:0] cap_count;

  assign s_ready   = !reset && !full;
  assign push      = s_valid && s_ready;
  assign slot_free = !r_valid_q || r_ready;

  minmax_fifo #(.W(MSB+1), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (s_data),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_CLR;
      cnt        <= '0;
      hold_q     <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hold_q     <= hold_nxt;
      flush_pend <= flush_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hold_nxt       = hold_q;
    flush_pend_nxt = flush_pend;
    pop            = 1'b0;
    capture        = 1'b0;
    cap_count      = cnt;
    f_in           = '0;
    f_clear        = 1'b0;
    f_enable       = 1'b0;
    f_reset        = 1'b0;
    if (reset) begin
      f_clear = 1'b1;
    end else begin
      case (state)
        ST_CLR: begin
          f_clear   = 1'b1;
          state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          // Single-sample frames end on the starting pop, so they need the slot up front.
          if (!empty && (FRAME_LEN > 1 || slot_free)) begin
            pop      = 1'b1;
            f_in     = head;
            f_enable = 1'b1;
            f_reset  = 1'b1;
            hold_nxt = head;
            cnt_nxt  = CW'(1);
            if (FRAME_LEN == 1) begin
              capture   = 1'b1;
              cap_count = CW'(FRAME_LEN);
            end else begin
              state_nxt = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // Enable stays high all frame; re-feeding hold_q is harmless to min/max.
          f_enable = 1'b1;
          f_in     = hold_q;
          if (s_flush || flush_pend) begin
            if (slot_free) begin
              capture        = 1'b1;
              cap_count      = cnt;
              flush_pend_nxt = 1'b0;
              state_nxt      = ST_IDLE;
            end else begin
              flush_pend_nxt = 1'b1;
            end
          end else if (!empty) begin
            if (cnt == CW'(FRAME_LEN-1)) begin
              if (slot_free) begin
                pop       = 1'b1;
                f_in      = head;
                hold_nxt  = head;
                cnt_nxt   = CW'(FRAME_LEN);
                capture   = 1'b1;
                cap_count = CW'(FRAME_LEN);
                state_nxt = ST_IDLE;
              end
            end else begin
              pop      = 1'b1;
              f_in     = head;
              hold_nxt = head;
              cnt_nxt  = cnt + CW'(1);
            end
          end
        end
        default: state_nxt = ST_CLR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_count_q <= '0;
    end else if (capture) begin
      r_valid_q <= 1'b1;
      r_data_q  <= f_out;
      r_count_q <= cap_count;
    end else if (r_ready) begin
      r_valid_q <= 1'b0;
    end
  end

  assign r_valid = r_valid_q && !reset;
  assign r_data  = reset ? '0 : r_data_q;
  assign r_count = reset ? '0 : r_count_q;
  assign busy    = !reset && (state == ST_RUN);
endmodule

// File: tb/tb_minmax_frame_feeder.sv
// Directed bench for minmax_frame_feeder with a behavioural min/max mid-range filter attached.
module tb_minmax_frame_feeder;
  localparam int MSB = 8;
  localparam int FL  = 4;
  localparam int DEP = 4;
  localparam int CW  = $clog2(FL+1);

  logic          clock = 1'b0;
  logic          reset;
  logic          s_valid, s_ready, s_flush;
  logic [MSB:0]  s_data;
  logic [MSB:0]  f_in, f_out;
  logic          f_clear, f_enable, f_reset;
  logic          r_valid, r_ready;
  logic [MSB:0]  r_data;
  logic [CW-1:0] r_count;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int results = 0;
  int accepted = 0;
  logic [MSB:0] last_start;

  minmax_frame_feeder #(.MSB(MSB), .FRAME_LEN(FL), .DEPTH(DEP)) dut (
    .clock    (clock),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_flush  (s_flush),
    .f_in     (f_in),
    .f_clear  (f_clear),
    .f_enable (f_enable),
    .f_reset  (f_reset),
    .f_out    (f_out),
    .r_valid  (r_valid),
    .r_ready  (r_ready),
    .r_data   (r_data),
    .r_count  (r_count),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  // Filter model: min/max including the current input, output (min+max)/2.
  logic [MSB:0] flt_mn, flt_mx, c_mn, c_mx;
  logic [MSB+1:0] flt_sum;
  always_comb begin
    c_mn = flt_mn;
    c_mx = flt_mx;
    if (f_enable) begin
      if (f_reset) begin
        c_mn = f_in;
        c_mx = f_in;
      end else begin
        c_mn = (f_in < flt_mn) ? f_in : flt_mn;
        c_mx = (f_in > flt_mx) ? f_in : flt_mx;
      end
    end
    flt_sum = {1'b0, c_mn} + {1'b0, c_mx};
    f_out   = flt_sum[MSB+1:1];
  end

  always @(posedge clock) begin
    if (f_clear) begin
      flt_mn <= '0;
      flt_mx <= '0;
    end else if (f_enable) begin
      flt_mn <= c_mn;
      flt_mx <= c_mx;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (f_enable && f_reset) begin
        starts++;
        last_start = f_in;
      end
      if (r_valid && r_ready) results++;
      if (s_valid && s_ready) accepted++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [MSB:0] d);
    logic ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_accept", ok, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int exp_d, input int exp_c);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (r_valid) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_valid"}, found, 1);
    check({tag, "_data"}, r_data, exp_d);
    check({tag, "_count"}, r_count, exp_c);
    check({tag, "_busy"}, busy, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0, a0, r0;
    reset = 1'b1; s_valid = 1'b0; s_data = '0; s_flush = 1'b0; r_ready = 1'b1;

    // T1: reset and CLR cycle
    @(negedge clock);
    check("t1_rst_clear", f_clear, 1);
    check("t1_rst_rvalid", r_valid, 0);
    check("t1_rst_sready", s_ready, 0);
    check("t1_rst_enable", f_enable, 0);
    tick(); tick();
    reset = 1'b0;
    @(negedge clock);
    check("t1_clr_clear", f_clear, 1);
    check("t1_clr_sready", s_ready, 1);
    check("t1_clr_busy", busy, 0);
    tick();
    @(negedge clock);
    check("t1_idle_clear", f_clear, 0);
    check("t1_idle_enable", f_enable, 0);
    tick();

    // T2: back-to-back full frame
    s0 = starts;
    send(10); send(200); send(50); send(30);
    wait_result("t2", 105, 4);
    check("t2_starts", starts - s0, 1);
    check("t2_start_val", last_start, 10);

    // T3: starvation mid-frame re-feeds the last sample
    send(10); send(200); send(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_hold", {f_enable, f_reset, f_in}, {1'b1, 1'b0, 9'd50});
    end
    tick();
    send(30);
    wait_result("t3", 105, 4);

    // T4: early flush, then a fresh frame
    s0 = starts;
    send(100); send(300);
    tick();
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    wait_result("t4", 200, 2);
    send(7); send(8); send(9); send(6);
    wait_result("t4b", 7, 4);
    check("t4_starts", starts - s0, 2);
    check("t4_start_val", last_start, 7);

    // T5: result slot held, second frame's final pop waits
    r_ready = 1'b0;
    send(511); send(511); send(0); send(0);
    send(4); send(4); send(4); send(4);
    repeat (6) tick();
    @(negedge clock);
    check("t5_held_valid", r_valid, 1);
    check("t5_held_data", r_data, 255);
    check("t5_held_count", r_count, 4);
    check("t5_stall_busy", busy, 1);
    tick();
    r_ready = 1'b1;
    @(negedge clock);
    check("t5_first_data", r_data, 255);
    tick();
    @(negedge clock);
    check("t5_second_valid", r_valid, 1);
    check("t5_second_data", r_data, 4);
    check("t5_second_count", r_count, 4);
    tick();
    @(negedge clock);
    check("t5_drained", r_valid, 0);
    tick();

    // T6: FIFO fills behind a blocked slot, then reset mid-frame
    r_ready = 1'b0;
    send(20); send(20); send(20); send(20);
    repeat (3) tick();
    a0 = accepted;
    s_valid = 1'b1;
    s_data  = 9'd9;
    repeat (10) tick();
    @(negedge clock);
    check("t6_full_sready", s_ready, 0);
    check("t6_full_busy", busy, 1);
    check("t6_slot_data", r_data, 20);
    tick();
    check("t6_accepted", accepted - a0, 7);
    reset   = 1'b1;
    s_valid = 1'b0;
    @(negedge clock);
    check("t6_rst_sready", s_ready, 0);
    check("t6_rst_rvalid", r_valid, 0);
    check("t6_rst_clear", f_clear, 1);
    check("t6_rst_enable", f_enable, 0);
    tick();
    reset   = 1'b0;
    r_ready = 1'b1;
    r0 = results;
    s0 = starts;
    @(negedge clock);
    check("t6_clr_clear", f_clear, 1);
    repeat (8) tick();
    check("t6_no_result", results - r0, 0);
    check("t6_no_start", starts - s0, 0);
    @(negedge clock);
    check("t6_rvalid", r_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_sready", s_ready, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
